// File: rtl/emif_shim_pkg.sv
// rtl/emif_shim_pkg.sv - shared types, constants and helpers for the EMIF shim command path
package emif_shim_pkg;

  // Default shim geometry; the skid buffer sizes its P_WIDTH from emif_cmd_t.
  localparam int ADDR_W         = 32;
  localparam int ID_W           = 4;
  localparam int MAX_BURST      = 64;
  localparam int BYTES_PER_BEAT = 64;
  localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
  localparam int OUT_LEN_W      = $clog2(MAX_BURST) + 1;

  // Sub-burst command word as it lands on the skid data bus.
  typedef struct packed {
    logic                 write;
    logic [ID_W-1:0]      id;
    logic                 last;
    logic [OUT_LEN_W-1:0] len;
    logic [ADDR_W-1:0]    addr;
  } emif_cmd_t;

  // Splitter control states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_t;

  // Smallest of three unsigned limits; used to pick the sub-burst size.
  function automatic logic [31:0] min3(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/emif_shim_chunk_calc.sv
// rtl/emif_shim_chunk_calc.sv - combinational sub-burst size and last flag; EMIF_SHIM_BOUNDARY_SPLIT_EN adds the boundary limit
module emif_shim_chunk_calc
  import emif_shim_pkg::*;
#(
  parameter int P_ADDR_W         = 32,
  parameter int P_LEN_W          = 8,
  parameter int P_MAX_BURST      = 64,
  parameter int P_BYTES_PER_BEAT = 64,
  parameter int P_BOUNDARY       = 4096
) (
  input  logic [P_ADDR_W-1:0] cur_addr,
  input  logic [P_LEN_W:0]    rem,
  output logic [P_LEN_W:0]    chunk,
  output logic                last
);

  localparam int REM_W = P_LEN_W + 1;

  logic [31:0] beats_to_boundary;
  logic        unused_addr;

`ifdef EMIF_SHIM_BOUNDARY_SPLIT_EN
  localparam int SHIFT = $clog2(P_BYTES_PER_BEAT);
  localparam int BND_W = $clog2(P_BOUNDARY);

  // Beats left before the next boundary-aligned address (cur_addr is beat-aligned).
  assign beats_to_boundary = (32'(P_BOUNDARY) - 32'(cur_addr[BND_W-1:0])) >> SHIFT;
`else
  localparam int unused_cfg = P_BOUNDARY + P_BYTES_PER_BEAT;

  // No boundary limit: the term never wins the minimum.
  assign beats_to_boundary = '1;
`endif

  // Only the low address bits matter for the boundary distance.
  assign unused_addr = ^cur_addr;

  assign chunk = REM_W'(min3(32'(rem), 32'(P_MAX_BURST), beats_to_boundary));
  assign last  = (chunk == rem);

endmodule

// File: rtl/emif_shim_burst_split.sv
// rtl/emif_shim_burst_split.sv - splits beat-based burst commands into sub-bursts of at most P_MAX_BURST beats; EMIF_SHIM_BOUNDARY_SPLIT_EN also splits at P_BOUNDARY
module emif_shim_burst_split
  import emif_shim_pkg::*;
#(
  parameter int P_ADDR_W         = 32,
  parameter int P_LEN_W          = 8,
  parameter int P_MAX_BURST      = 64,
  parameter int P_BYTES_PER_BEAT = 64,
  parameter int P_ID_W           = 4,
  parameter int P_BOUNDARY       = 4096
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [P_ADDR_W-1:0]              in_addr,
  input  logic [P_LEN_W-1:0]               in_len,
  input  logic                             in_write,
  input  logic [P_ID_W-1:0]                in_id,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [P_ADDR_W-1:0]              out_addr,
  output logic [$clog2(P_MAX_BURST):0]     out_len,
  output logic                             out_write,
  output logic [P_ID_W-1:0]                out_id,
  output logic                             out_last
);

  localparam int SHIFT  = $clog2(P_BYTES_PER_BEAT);
  localparam int REM_W  = P_LEN_W + 1;
  localparam int OLEN_W = $clog2(P_MAX_BURST) + 1;
  localparam logic [P_ADDR_W-1:0] LOW_MASK = P_ADDR_W'((64'd1 << SHIFT) - 64'd1);

  split_state_t        state;
  logic [P_ADDR_W-1:0] cur_addr;
  logic [REM_W-1:0]    rem;
  logic [REM_W-1:0]    chunk;
  logic                wr;
  logic [P_ID_W-1:0]   id;
  logic                last;
  logic                take;
  logic                accept;

  emif_shim_chunk_calc #(
    .P_ADDR_W        (P_ADDR_W),
    .P_LEN_W         (P_LEN_W),
    .P_MAX_BURST     (P_MAX_BURST),
    .P_BYTES_PER_BEAT(P_BYTES_PER_BEAT),
    .P_BOUNDARY      (P_BOUNDARY)
  ) u_chunk_calc (
    .cur_addr(cur_addr),
    .rem     (rem),
    .chunk   (chunk),
    .last    (last)
  );

  assign out_valid = (state == ST_SPLIT);
  assign take      = out_valid & out_ready;
  // The final sub-burst leaving frees the slot for a new command in the same cycle.
  assign in_ready  = (state == ST_IDLE) | (take & last);
  assign accept    = in_valid & in_ready;

  // Outputs read as zero whenever no sub-burst is offered.
  assign out_addr  = out_valid ? cur_addr : '0;
  assign out_len   = out_valid ? OLEN_W'(chunk - REM_W'(1)) : '0;
  assign out_last  = out_valid & last;
  assign out_write = out_valid & wr;
  assign out_id    = out_valid ? id : '0;

  // Command capture and sub-burst advance; a same-cycle accept overrides the advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cur_addr <= '0;
      rem      <= '0;
      wr       <= 1'b0;
      id       <= '0;
    end else begin
      if (take) begin
        cur_addr <= cur_addr + (P_ADDR_W'(chunk) << SHIFT);
        rem      <= rem - chunk;
        if (last) begin
          state <= ST_IDLE;
        end
      end
      if (accept) begin
        cur_addr <= in_addr & ~LOW_MASK;
        rem      <= REM_W'(in_len) + REM_W'(1);
        wr       <= in_write;
        id       <= in_id;
        state    <= ST_SPLIT;
      end
    end
  end

endmodule

// File: tb/tb_emif_shim_burst_split.sv
// tb/tb_emif_shim_burst_split.sv - randomized self-checking bench for emif_shim_burst_split
module tb_emif_shim_burst_split;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [7:0]  in_len;
  logic        in_write;
  logic [3:0]  in_id;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [6:0]  out_len;
  logic        out_write;
  logic [3:0]  out_id;
  logic        out_last;

  always #5 clk = ~clk;

  emif_shim_burst_split dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_len   (in_len),
    .in_write (in_write),
    .in_id    (in_id),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_len  (out_len),
    .out_write(out_write),
    .out_id   (out_id),
    .out_last (out_last)
  );

  typedef struct {
    logic [31:0] addr;
    logic [6:0]  len;
    logic        last;
    logic [3:0]  id;
    logic        wr;
    int          cyc;
  } sb_t;

  sb_t         exp_q[$];
  sb_t         log_q[$];
  sb_t         e;
  sb_t         o;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          ready_pct = 100;
  logic        stall_prev = 1'b0;
  logic [44:0] held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference split: walk the command in address order taking the largest legal piece.
  function automatic void model_push(input logic [31:0] addr, input logic [7:0] len,
                                     input logic wr, input logic [3:0] id);
    logic [31:0] a;
    int          r;
    int          c;
    int          btb;
    sb_t         n;
    a = addr & 32'hFFFF_FFC0;
    r = int'(len) + 1;
    while (r > 0) begin
      c = (r > 64) ? 64 : r;
      btb = (4096 - int'(a % 32'd4096)) / 64;
`ifdef EMIF_SHIM_BOUNDARY_SPLIT_EN
      if (c > btb) c = btb;
`endif
      n.addr = a;
      n.len  = 7'(c - 1);
      n.last = (c == r);
      n.id   = id;
      n.wr   = wr;
      n.cyc  = 0;
      exp_q.push_back(n);
      a = a + 32'(c * 64);
      r = r - c;
    end
  endfunction

  // Per-cycle compare against the reference queue, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (stall_prev) begin
        chk("stall_stable", 64'({out_addr, out_len, out_last, out_id, out_write}), 64'(held));
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_addr", 64'(out_addr), 64'(e.addr));
        chk("out_len", 64'(out_len), 64'(e.len));
        chk("out_last", 64'(out_last), 64'(e.last));
        chk("out_id", 64'(out_id), 64'(e.id));
        chk("out_write", 64'(out_write), 64'(e.wr));
        o.addr = out_addr;
        o.len  = out_len;
        o.last = out_last;
        o.id   = out_id;
        o.wr   = out_write;
        o.cyc  = cyc;
        log_q.push_back(o);
      end
      stall_prev = out_valid && !out_ready;
      held = {out_addr, out_len, out_last, out_id, out_write};
      if (in_valid && in_ready) begin
        model_push(in_addr, in_len, in_write, in_id);
        acc_cyc = cyc;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = ($urandom_range(0, 99) < ready_pct);
  end

  task automatic send(input logic [31:0] a, input logic [7:0] l, input logic w,
                      input logic [3:0] i, input bit keep, output int waits);
    bit got;
    got = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_addr = a;
    in_len = l;
    in_write = w;
    in_id = i;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge clk);
      waits++;
      if (in_ready) got = 1'b1;
    end
    chk("send_accept", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 5000 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    chk("idle_reached", 64'(done), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_log(input int idx, input logic [31:0] a, input logic [6:0] l,
                            input logic lst);
    if (idx < log_q.size()) begin
      chk($sformatf("lit%0d_addr", idx), 64'(log_q[idx].addr), 64'(a));
      chk($sformatf("lit%0d_len", idx), 64'(log_q[idx].len), 64'(l));
      chk($sformatf("lit%0d_last", idx), 64'(log_q[idx].last), 64'(lst));
    end else begin
      chk($sformatf("lit%0d_present", idx), 64'(log_q.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    int w;
    int sum;
    in_valid = 1'b0;
    in_addr = '0;
    in_len = '0;
    in_write = 1'b0;
    in_id = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_fields", 64'({out_addr, out_len, out_last, out_id, out_write}), 64'd0);

    // Single short command, latency one cycle.
    log_q.delete();
    send(32'h1000, 8'd3, 1'b1, 4'h3, 1'b0, w);
    wait_idle();
    chk("short_count", 64'(log_q.size()), 64'd1);
    expect_log(0, 32'h1000, 7'd3, 1'b1);
    if (log_q.size() > 0) chk("short_latency", 64'(log_q[0].cyc - acc_cyc), 64'd1);

    // Long command split by max burst.
    log_q.delete();
    send(32'h0, 8'd199, 1'b0, 4'h5, 1'b0, w);
    wait_idle();
    chk("long_count", 64'(log_q.size()), 64'd4);
    expect_log(0, 32'h0000, 7'd63, 1'b0);
    expect_log(1, 32'h1000, 7'd63, 1'b0);
    expect_log(2, 32'h2000, 7'd63, 1'b0);
    expect_log(3, 32'h3000, 7'd7, 1'b1);

    // Boundary straddle.
    log_q.delete();
    send(32'h0FC0, 8'd3, 1'b1, 4'h6, 1'b0, w);
    wait_idle();
`ifdef EMIF_SHIM_BOUNDARY_SPLIT_EN
    chk("bnd_count", 64'(log_q.size()), 64'd2);
    expect_log(0, 32'h0FC0, 7'd0, 1'b0);
    expect_log(1, 32'h1000, 7'd2, 1'b1);
`else
    chk("bnd_count", 64'(log_q.size()), 64'd1);
    expect_log(0, 32'h0FC0, 7'd3, 1'b1);
`endif

    // Backpressure on a long command.
    ready_pct = 30;
    log_q.delete();
    send(32'h0, 8'd199, 1'b0, 4'h7, 1'b0, w);
    wait_idle();
    ready_pct = 100;
    chk("bp_count", 64'(log_q.size()), 64'd4);
    sum = 0;
    foreach (log_q[k]) sum += int'(log_q[k].len) + 1;
    chk("bp_beat_sum", 64'(sum), 64'd200);
    expect_log(3, 32'h3000, 7'd7, 1'b1);

    // Back-to-back single-beat commands.
    @(posedge clk);
    #1;
    log_q.delete();
    for (int i = 0; i < 5; i++) begin
      send(32'(i * 64), 8'd0, 1'b0, 4'(i + 1), (i < 4), w);
      chk("b2b_wait", 64'(w), 64'd1);
    end
    wait_idle();
    chk("b2b_count", 64'(log_q.size()), 64'd5);
    foreach (log_q[k]) begin
      chk("b2b_id", 64'(log_q[k].id), 64'(k + 1));
      chk("b2b_cycle", 64'(log_q[k].cyc - log_q[0].cyc), 64'(k));
    end

    // Reset after the second sub-burst.
    log_q.delete();
    send(32'h0, 8'd199, 1'b0, 4'h9, 1'b0, w);
    for (int t = 0; t < 200 && log_q.size() < 2; t++) @(negedge clk);
    chk("rst_mid_reached", 64'(log_q.size()), 64'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    log_q.delete();
    send(32'h5010, 8'd69, 1'b1, 4'hA, 1'b0, w);
    wait_idle();
    chk("after_rst_count", 64'(log_q.size()), 64'd2);
    expect_log(0, 32'h5000, 7'd63, 1'b0);
    expect_log(1, 32'h6000, 7'd5, 1'b1);

    // Address wrap plus randomized commands under random backpressure.
    send(32'hFFFF_FFC0, 8'd1, 1'b0, 4'hB, 1'b0, w);
    ready_pct = 70;
    for (int n = 0; n < 40; n++) begin
      send($urandom, 8'($urandom_range(0, 255)), 1'($urandom), 4'($urandom),
           (n < 39) && ($urandom_range(0, 1) == 1), w);
    end
    wait_idle();
    ready_pct = 100;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
